// File: rtl/out_port_buffer_if.sv
// Bus bundle between control/device side (master) and the output-port buffer (slave).
interface out_port_buffer_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2
);
  localparam int unsigned PORTS = 2 ** ADDR_W;

  logic                      wr_en;
  logic [ADDR_W-1:0]         port_sel;
  logic [DATA_W-1:0]         A_Result;
  logic                      full;
  logic                      empty;
  logic                      overflow;
  logic                      dev_req;
  logic [ADDR_W-1:0]         dev_port;
  logic [DATA_W-1:0]         dev_data;
  logic                      dev_ack;
  logic [PORTS*DATA_W-1:0]   port_q;

  modport master (
    output wr_en, port_sel, A_Result, dev_ack,
    input  full, empty, overflow, dev_req, dev_port, dev_data, port_q
  );

  modport slave (
    input  wr_en, port_sel, A_Result, dev_ack,
    output full, empty, overflow, dev_req, dev_port, dev_data, port_q
  );
endinterface

// File: rtl/out_port_buffer.sv
// Output-port stage: FIFO of {port, data} pushes drained over a four-phase
// req/ack handshake into per-port holding registers.
module out_port_buffer #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  out_port_buffer_if.slave bus
);
  localparam int unsigned PORTS   = 2 ** ADDR_W;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]                     state_q,    state_d;
  logic [ENTRY_W-1:0]             mem_q [DEPTH];
  logic [ENTRY_W-1:0]             mem_d [DEPTH];
  logic [PTR_W-1:0]               wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]               rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]               count_q,    count_d;
  logic                           overflow_q, overflow_d;
  logic                           dev_req_q,  dev_req_d;
  logic [ADDR_W-1:0]              dev_port_q, dev_port_d;
  logic [DATA_W-1:0]              dev_data_q, dev_data_d;
  logic [PORTS-1:0][DATA_W-1:0]   port_q_q,   port_q_d;

  logic                           full_c;
  logic                           empty_c;
  logic                           push;
  logic                           pop;
  logic [ENTRY_W-1:0]             head_c;

  // Status decoded from the registered count, so a same-cycle pop never frees room for a push.
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == CNT_W'(0));
  assign head_c  = mem_q[rd_ptr_q];

  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.overflow = overflow_q;
  assign bus.dev_req  = dev_req_q;
  assign bus.dev_port = dev_port_q;
  assign bus.dev_data = dev_data_q;
  assign bus.port_q   = port_q_q;

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    dev_req_d  = dev_req_q;
    dev_port_d = dev_port_q;
    dev_data_d = dev_data_q;
    port_q_d   = port_q_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (bus.wr_en) begin
      if (full_c) begin
        overflow_d = 1'b1;
      end else begin
        push            = 1'b1;
        mem_d[wr_ptr_q] = {bus.port_sel, bus.A_Result};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!empty_c) begin
          dev_port_d = head_c[ENTRY_W-1 -: ADDR_W];
          dev_data_d = head_c[DATA_W-1:0];
          dev_req_d  = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.dev_ack) begin
          dev_req_d            = 1'b0;
          pop                  = 1'b1;
          rd_ptr_d             = rd_ptr_q + PTR_W'(1);
          port_q_d[dev_port_q] = dev_data_q;
          state_d              = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!bus.dev_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        dev_req_d = 1'b0;
      end
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dev_req_q  <= 1'b0;
      dev_port_q <= '0;
      dev_data_q <= '0;
      port_q_q   <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dev_req_q  <= dev_req_d;
      dev_port_q <= dev_port_d;
      dev_data_q <= dev_data_d;
      port_q_q   <= port_q_d;
    end
  end
endmodule

// File: tb/tb_out_port_buffer.sv
// Self-checking bench for out_port_buffer: directed scenarios plus random traffic
// checked against a transaction-level queue model of pushes and deliveries.
module tb_out_port_buffer;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int PORTS  = 4;

  typedef struct {
    logic [ADDR_W-1:0] port;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic clk;
  logic reset;

  out_port_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  out_port_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  ent_t              m_q[$];
  logic [DATA_W-1:0] m_port [PORTS];
  bit                m_ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge with the model advanced alongside the DUT.
  task automatic tick();
    bit                      hs;
    bit                      acc;
    ent_t                    e;
    logic [PORTS*DATA_W-1:0] exp_pq;
    hs = (bus.dev_req === 1'b1) && (bus.dev_ack === 1'b1);
    if (bus.dev_req === 1'b1) begin
      n_cmp++;
      if (m_q.size() == 0) begin
        n_err++;
        $display("FAIL req_without_entry: dev_req=1 but model queue is empty");
      end else if ({bus.dev_port, bus.dev_data} !== {m_q[0].port, m_q[0].data}) begin
        n_err++;
        $display("FAIL dev_payload: got port=%0d data=%h, need port=%0d data=%h",
                 bus.dev_port, bus.dev_data, m_q[0].port, m_q[0].data);
      end
    end
    acc = (bus.wr_en === 1'b1) && (m_q.size() < DEPTH);
    if (bus.wr_en === 1'b1 && !acc) m_ovf = 1'b1;
    e.port = bus.port_sel;
    e.data = bus.A_Result;
    @(posedge clk);
    #1;
    if (hs && m_q.size() != 0) begin
      m_port[m_q[0].port] = m_q[0].data;
      void'(m_q.pop_front());
    end
    if (acc) m_q.push_back(e);
    bus.wr_en = 1'b0;
    for (int k = 0; k < PORTS; k++) exp_pq[k*DATA_W +: DATA_W] = m_port[k];
    n_cmp++;
    if (bus.port_q !== exp_pq) begin
      n_err++;
      $display("FAIL port_q: got %h, need %h", bus.port_q, exp_pq);
    end
    n_cmp++;
    if (bus.overflow !== m_ovf) begin
      n_err++;
      $display("FAIL overflow: got %b, need %b", bus.overflow, m_ovf);
    end
    n_cmp++;
    if (bus.full !== (m_q.size() == DEPTH) || bus.empty !== (m_q.size() == 0)) begin
      n_err++;
      $display("FAIL full_empty: got full=%b empty=%b, need count=%0d", bus.full, bus.empty, m_q.size());
    end
  endtask

  task automatic push(input int p, input int d);
    bus.port_sel = ADDR_W'(p);
    bus.A_Result = DATA_W'(d);
    bus.wr_en    = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    bus.dev_ack = 1'b0;
    m_q.delete();
    for (int k = 0; k < PORTS; k++) m_port[k] = '0;
    m_ovf = 1'b0;
  endtask

  // Device side completes handshakes until the buffer is empty and idle.
  task automatic drain();
    int guard = 0;
    while (guard < 300 && (m_q.size() != 0 || bus.dev_ack === 1'b1 || bus.dev_req === 1'b1)) begin
      if (bus.dev_req === 1'b1 && bus.dev_ack === 1'b0) bus.dev_ack = 1'b1;
      else if (bus.dev_req === 1'b0 && bus.dev_ack === 1'b1) bus.dev_ack = 1'b0;
      tick();
      guard++;
    end
    n_cmp++;
    if (guard >= 300) begin
      n_err++;
      $display("FAIL drain_timeout: %0d entries left after %0d cycles", m_q.size(), guard);
    end
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b, need 0", bus.full); end
    n_cmp++;
    if (bus.empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b, need 1", bus.empty); end
    n_cmp++;
    if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b, need 0", bus.overflow); end
    n_cmp++;
    if (bus.dev_req !== 1'b0) begin n_err++; $display("FAIL rst_dev_req: got %b, need 0", bus.dev_req); end
    n_cmp++;
    if (bus.dev_port !== '0 || bus.dev_data !== '0) begin
      n_err++;
      $display("FAIL rst_dev_bus: got port=%0d data=%h, need 0/0", bus.dev_port, bus.dev_data);
    end
    n_cmp++;
    if (bus.port_q !== '0) begin n_err++; $display("FAIL rst_port_q: got %h, need 0", bus.port_q); end
  endtask

  task automatic test_single();
    do_reset();
    push(2, 'hA);
    n_cmp++;
    if (bus.dev_req !== 1'b0) begin n_err++; $display("FAIL single_req_early: got %b, need 0", bus.dev_req); end
    tick();
    n_cmp++;
    if (bus.dev_req !== 1'b1 || bus.dev_port !== 2'd2 || bus.dev_data !== 4'hA) begin
      n_err++;
      $display("FAIL single_req: got req=%b port=%0d data=%h, need 1/2/a", bus.dev_req, bus.dev_port, bus.dev_data);
    end
    bus.dev_ack = 1'b1;
    tick();
    n_cmp++;
    if (bus.dev_req !== 1'b0 || bus.port_q !== 16'h0A00) begin
      n_err++;
      $display("FAIL single_ack: got req=%b port_q=%h, need 0/0a00", bus.dev_req, bus.port_q);
    end
    bus.dev_ack = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b, need 1", bus.empty); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) push(i, i + 1);
    n_cmp++;
    if (bus.full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b, need 1", bus.full); end
    push(0, 'hF);
    n_cmp++;
    if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b, need 1", bus.overflow); end
    drain();
    n_cmp++;
    if (bus.port_q !== 16'h4321) begin n_err++; $display("FAIL ovf_port_q: got %h, need 4321", bus.port_q); end
  endtask

  task automatic test_full_ack_push();
    do_reset();
    for (int i = 0; i < 4; i++) push(3 - i, 8 + i);
    bus.dev_ack = 1'b1;
    push(0, 5);
    n_cmp++;
    if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL fullpop_overflow: got %b, need 1", bus.overflow); end
    n_cmp++;
    if (dut.count_q !== 3'd3 || bus.full !== 1'b0) begin
      n_err++;
      $display("FAIL fullpop_count: got count=%0d full=%b, need 3/0", dut.count_q, bus.full);
    end
    drain();
    n_cmp++;
    if (bus.port_q !== 16'h89AB) begin n_err++; $display("FAIL fullpop_port_q: got %h, need 89ab", bus.port_q); end
  endtask

  task automatic test_push_pop();
    do_reset();
    push(1, 6);
    push(2, 9);
    n_cmp++;
    if (bus.dev_req !== 1'b1) begin n_err++; $display("FAIL pp_req: got %b, need 1", bus.dev_req); end
    bus.dev_ack = 1'b1;
    push(3, 'hC);
    n_cmp++;
    if (dut.count_q !== 3'd2) begin n_err++; $display("FAIL pp_count: got %0d, need 2", dut.count_q); end
    drain();
    n_cmp++;
    if (bus.port_q !== 16'hC960) begin n_err++; $display("FAIL pp_port_q: got %h, need c960", bus.port_q); end
  endtask

  task automatic test_release_hold();
    do_reset();
    push(0, 3);
    push(1, 5);
    bus.dev_ack = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (bus.dev_req !== 1'b0) begin n_err++; $display("FAIL hold_req_c%0d: got %b, need 0", i, bus.dev_req); end
    end
    bus.dev_ack = 1'b0;
    tick();
    n_cmp++;
    if (bus.dev_req !== 1'b0) begin n_err++; $display("FAIL hold_req_idle: got %b, need 0", bus.dev_req); end
    tick();
    n_cmp++;
    if (bus.dev_req !== 1'b1 || bus.dev_port !== 2'd1 || bus.dev_data !== 4'h5) begin
      n_err++;
      $display("FAIL hold_rearm: got req=%b port=%0d data=%h, need 1/1/5", bus.dev_req, bus.dev_port, bus.dev_data);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(1, 7);
    tick();
    n_cmp++;
    if (bus.dev_req !== 1'b1 || bus.dev_data !== 4'h7 || bus.dev_port !== 2'd1) begin
      n_err++;
      $display("FAIL mid_setup: got req=%b port=%0d data=%h, need 1/1/7", bus.dev_req, bus.dev_port, bus.dev_data);
    end
    bus.dev_ack = 1'b1;
    do_reset();
    n_cmp++;
    if (bus.dev_req !== 1'b0 || bus.dev_port !== '0 || bus.dev_data !== '0 || bus.port_q !== '0 ||
        bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got req=%b port=%0d data=%h port_q=%h empty=%b, need all reset values",
               bus.dev_req, bus.dev_port, bus.dev_data, bus.port_q, bus.empty);
    end
    n_cmp++;
    if (dut.state_q !== 2'd0) begin n_err++; $display("FAIL mid_state: got %0d, need idle", dut.state_q); end
    for (int i = 0; i < 6; i++) begin
      bus.dev_ack = i[0];
      tick();
    end
    bus.dev_ack = 1'b0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.port_sel = ADDR_W'($urandom_range(0, PORTS - 1));
        bus.A_Result = DATA_W'($urandom_range(0, 15));
        bus.wr_en    = 1'b1;
      end
      if (bus.dev_req === 1'b1 && bus.dev_ack === 1'b0 && $urandom_range(0, 1) == 1) bus.dev_ack = 1'b1;
      else if (bus.dev_req === 1'b0 && bus.dev_ack === 1'b1 && $urandom_range(0, 1) == 1) bus.dev_ack = 1'b0;
      tick();
    end
    drain();
  endtask

  initial begin
    reset        = 1'b1;
    bus.wr_en    = 1'b0;
    bus.port_sel = '0;
    bus.A_Result = '0;
    bus.dev_ack  = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_full_ack_push();
    test_push_pop();
    test_release_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
